overlap_collect_unit: RTL

OVERLAP_COLLECT_UNIT -- requirements
Module: overlap_collect_unit

---
 rtl/obs_ovl_pkg.sv | 20 ++
 rtl/overlap_combine.sv | 33 +++
 rtl/overlap_collect_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/obs_ovl_pkg.sv
// Shared definitions for the overlap collect unit.
//   SLOTS        : number of sub-product slots collected per result
//   SLOT_IN1..4  : slot index encodings carried on s_idx
//   ovl_state_t  : collector FSM state encoding
package obs_ovl_pkg;

  localparam int unsigned SLOTS = 4;

  localparam logic [1:0] SLOT_IN1 = 2'd0;
  localparam logic [1:0] SLOT_IN2 = 2'd1;
  localparam logic [1:0] SLOT_IN3 = 2'd2;
  localparam logic [1:0] SLOT_IN4 = 2'd3;

  typedef enum logic [1:0] {
    COLLECT,
    COMBINE,
    OUTPUT
  } ovl_state_t;

endpackage

// File: rtl/overlap_combine.sv
// Combinational interleave of four W-bit sub-products into a 2W+1-bit result.
//   in1..in4 : sub-products (W bits each)
//   comb     : even bit 2i = in1[i] ^ in4[i-1] (i = 0..W, out-of-range bits read 0)
//              odd  bit 2i+1 = in2[i] ^ in3[i] (i = 0..W-1)
module overlap_combine #(
  parameter int unsigned W = 49
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  output logic [2*W:0] comb
);

  // Zero-extend in1 and shift in4 up one place so both even-lane
  // operands line up on index i with the boundary bits reading 0.
  logic [W:0] in1_ext;
  logic [W:0] in4_sh;

  assign in1_ext = {1'b0, in1};
  assign in4_sh  = {in4, 1'b0};

  always_comb begin
    comb = '0;
    for (int unsigned i = 0; i <= W; i++) begin
      comb[2*i] = in1_ext[i] ^ in4_sh[i];
    end
    for (int unsigned i = 0; i < W; i++) begin
      comb[2*i+1] = in2[i] ^ in3[i];
    end
  end

endmodule

// File: rtl/overlap_collect_unit.sv
// Collects four W-bit sub-products (any slot order) over a valid/ready
// input, combines them into one 2W+1-bit overlap result and presents it
// on a valid/ready output.
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : input beat handshake; s_idx selects slot, s_data is the beat
//   m_valid/m_ready   : result handshake; m_data holds the combined result
//   err_dup           : one-cycle pulse after a beat rewrites an already-loaded slot
//   acc_clr           : (OBS_OVL_ACCUM_EN only) clear the XOR accumulator
// Optional feature: define OBS_OVL_ACCUM_EN to XOR every result into a
// running accumulator that is also what m_data reports.
module overlap_collect_unit
  import obs_ovl_pkg::*;
#(
  parameter int unsigned W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [1:0]   s_idx,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [2*W:0] m_data,
`ifdef OBS_OVL_ACCUM_EN
  input  logic         acc_clr,
`endif
  output logic         err_dup
);

  ovl_state_t       state;
  logic [SLOTS-1:0] mask;
  logic [SLOTS-1:0] mask_set;
  logic [W-1:0]     slot [SLOTS];
  logic [2*W:0]     comb;
  logic [2*W:0]     result;
  logic             accept;

  assign s_ready = (state == COLLECT);
  assign accept  = s_valid && s_ready;

  always_comb begin
    mask_set        = mask;
    mask_set[s_idx] = 1'b1;
  end

  overlap_combine #(
    .W(W)
  ) u_combine (
    .in1  (slot[SLOT_IN1]),
    .in2  (slot[SLOT_IN2]),
    .in3  (slot[SLOT_IN3]),
    .in4  (slot[SLOT_IN4]),
    .comb (comb)
  );

`ifdef OBS_OVL_ACCUM_EN
  logic [2*W:0] acc;

  // A clear in the combine cycle makes this result start a fresh chain.
  assign result = comb ^ (acc_clr ? '0 : acc);
`else
  assign result = comb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      mask    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      err_dup <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot[i] <= '0;
      end
`ifdef OBS_OVL_ACCUM_EN
      acc <= '0;
`endif
    end else begin
      err_dup <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            slot[s_idx] <= s_data;
            mask        <= mask_set;
            err_dup     <= mask[s_idx];
            if (&mask_set) begin
              state <= COMBINE;
            end
          end
        end
        COMBINE: begin
          m_data  <= result;
          m_valid <= 1'b1;
          state   <= OUTPUT;
        end
        OUTPUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            mask    <= '0;
            state   <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
`ifdef OBS_OVL_ACCUM_EN
      if (state == COMBINE) begin
        acc <= result;
      end else if (acc_clr) begin
        acc <= '0;
      end
`endif
    end
  end

endmodule
